// File: rtl/dp_pipe_ctrl.sv
// Issue and flow controller for the multi-precision dot-product pipeline.
// Drives calculate_mode and per-stage enables/valids; global stall on backpressure.
`ifndef HALF_MODE
`define HALF_MODE 1'b1
`endif

module dp_pipe_ctrl #(
  parameter int PIPE_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic                  in_last,
  output logic                  calculate_mode,
  output logic [PIPE_DEPTH-1:0] stage_en,
  output logic [PIPE_DEPTH-1:0] stage_vld,
  output logic [PIPE_DEPTH-1:0] acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic             vld;
    logic             first;
    logic             last;
    logic [TAG_W-1:0] tag;
  } slot_t;

  state_t                   st_q;
  state_t                   st_d;
  slot_t [PIPE_DEPTH-1:0]   pipe_q;
  slot_t                    head;
  logic [TAG_W-1:0]         tag_q;
  logic                     grp_q;
  logic                     mode_q;
  logic                     adv;
  logic                     empty;
  logic                     mismatch;
  logic                     rdy;
  logic                     accept;

  always_comb begin
    stage_vld = '0;
    acc_clr   = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      stage_vld[i] = pipe_q[i].vld;
      acc_clr[i]   = pipe_q[i].vld & pipe_q[i].first;
    end
  end

  assign empty    = ~|stage_vld;
  assign adv      = ~pipe_q[PIPE_DEPTH-1].vld | out_ready;
  assign stage_en = {PIPE_DEPTH{adv}};

  // Only the first op of a group may request a precision change.
  assign mismatch = ~grp_q & in_valid & (in_mode != mode_q);

  always_comb begin
    st_d = st_q;
    rdy  = 1'b0;
    unique case (st_q)
      IDLE: begin
        rdy = 1'b1;
        if (in_valid) st_d = RUN;
      end
      RUN: begin
        rdy = adv & ~mismatch;
        if (mismatch)               st_d = DRAIN;
        else if (empty & ~in_valid) st_d = IDLE;
        else if (empty & ~adv)      st_d = IDLE;
      end
      DRAIN: begin
        if (empty) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign in_ready = rdy & rst_n;
  assign accept   = in_valid & in_ready;

  always_comb begin
    head       = '0;
    head.vld   = accept;
    head.first = accept & ~grp_q;
    head.last  = accept & in_last;
    head.tag   = tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      pipe_q <= '0;
      tag_q  <= '0;
      grp_q  <= 1'b0;
      mode_q <= ~`HALF_MODE;
    end else begin
      st_q <= st_d;
      if (accept) begin
        tag_q <= tag_q + TAG_W'(1);
        grp_q <= ~in_last;
        if (!grp_q) mode_q <= in_mode;
      end
      if (adv) begin
        pipe_q[0] <= head;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end
  end

  assign calculate_mode = mode_q;
  assign out_valid      = pipe_q[PIPE_DEPTH-1].vld;
  assign out_tag        = pipe_q[PIPE_DEPTH-1].tag;
  assign out_last       = pipe_q[PIPE_DEPTH-1].vld & pipe_q[PIPE_DEPTH-1].last;
  assign busy           = ~empty | (st_q != IDLE);

endmodule

// File: doc/dp_pipe_ctrl.md
# dp_pipe_ctrl

Issue and flow controller for the multi-precision dot-product pipeline (DP_pipe). Accepts operand-group issue requests over a valid/ready handshake, drives `calculate_mode` and per-stage enables/valids for the PIPE_DEPTH-stage datapath, and returns completion with tag and group markers. Half↔single mode changes are allowed only on an empty pipeline; output backpressure stalls the whole pipe. Sits between the operand source and the DP_pipe stage registers (pipe_1 unpack onward).

## Interface
- PIPE_DEPTH, 4, number of registered datapath stages (≥2)
- TAG_W, 4, width of issue tag counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set (x1..x4, y1..y4) presented
- in_ready  out  1  controller accepts this cycle
- in_mode  in  1  requested precision; equal to `half_mode → half, else single
- in_last  in  1  last operand set of an accumulation group
- calculate_mode  out  1  current pipe mode; feeds pipe_1 and downstream stages
- stage_en  out  PIPE_DEPTH  register enable per stage
- stage_vld  out  PIPE_DEPTH  occupancy per stage; bit 0 = first stage
- acc_clr  out  PIPE_DEPTH  per-stage "first op of group" flag (accumulator clear)
- out_valid  out  1  stage PIPE_DEPTH-1 holds a result
- out_ready  in  1  consumer takes result
- out_tag  out  TAG_W  tag of result at output
- out_last  out  1  result closes a group
- busy  out  1  any stage_vld bit set or state ≠ IDLE

## Operation
- States: IDLE (pipe empty), RUN, DRAIN.
- adv = ~stage_vld[PIPE_DEPTH-1] | out_ready; stage_en[i] = adv for all i (global stall, no bubble collapse).
- accept = in_valid & in_ready. On adv, stage 0 loads accept (vld, tag, first, last); stage i loads stage i-1.
- Tag counter increments by 1 per accept, wraps 2^TAG_W-1 → 0. Tag travels with op.
- Group tracking: in_grp flag set on accept with in_last=0, cleared on accept with in_last=1. acc_clr bit of stage 0 = ~in_grp at accept.
- Mode sampled only at first op of a group (in_grp=0). Inside a group in_mode is ignored; op uses calculate_mode.
- IDLE: in_ready=1. Accept → calculate_mode <= in_mode, RUN.
- RUN: in_ready=adv, except when in_grp=0 & in_valid & in_mode≠calculate_mode → in_ready=0, go DRAIN.
- RUN → IDLE when stage_vld all 0 and no accept this cycle.
- DRAIN: in_ready=0; pipe continues advancing; when stage_vld all 0 → IDLE (one bubble cycle), then new mode accepted.
- out_valid=stage_vld[PIPE_DEPTH-1]; out_tag/out_last from that stage; stage clears on out_ready unless refilled.
- Output held stable while out_valid & ~out_ready.

## Timing
- Reset (async, any time, including mid-group or DRAIN): state IDLE, stage_vld=0, acc_clr=0, tag=0, in_grp=0, calculate_mode=single (≠`half_mode), in_ready=0 while rst_n=0 then 1 from first cycle after release, out_valid=0, out_last=0, out_tag=0, busy=0. In-flight ops discarded.
- Latency: op accepted at edge k is at output (out_valid=1) after edge k+PIPE_DEPTH-1 with no stalls; throughput 1/cycle.
- Stall: out_valid & ~out_ready freezes all stages and in_ready=0 same cycle (combinational from out_ready).
- Simultaneous out_ready and accept with full pipe: both proceed, no loss.
- Mode switch cost: pipe occupancy drain + 1 IDLE cycle.
- in_ready does not depend on in_valid except the mode-mismatch check.

## Test plan
- Single-mode stream, PIPE_DEPTH=4: 8 back-to-back accepts, out_ready=1 → out_valid 4th..11th cycle after first accept, tags 0..7 in order, no gaps.
- Backpressure: fill pipe, hold out_ready=0 for 5 cycles → in_ready=0, stage_vld=4'b1111, out_tag stable; release → resumes with no drop/dup.
- Mode switch: group of 3 single ops, then in_mode=`half_mode first op → DRAIN, in_ready=0 until output empties, 1 IDLE cycle, then accept with calculate_mode=half.
- In-group mode ignored: in_last=0,0,1 with in_mode toggling on ops 2–3 → no DRAIN, calculate_mode unchanged, acc_clr set only on op 1, out_last only on op 3.
- Tag wrap: 20 accepts with TAG_W=4 → out_tag sequence 0..15,0..3.
- Async reset mid-DRAIN with 2 ops in flight → all outputs to reset values immediately, no out_valid after release, next accept gets tag 0.
